// File: rtl/pkmc_sdram_refresh_timer_pkg.sv
// Shared types and defaults for the pkmc SDRAM refresh timer.
// The two-state timer encoding and the default timing values live here.
package pkmc_sdram_refresh_timer_pkg;

    typedef enum logic {
        PWRUP = 1'b0,
        RUN   = 1'b1
    } refState_e;

    // 200 us power-up wait and 7.8 us refresh interval at 50 MHz
    localparam int unsigned DEFAULT_INIT_CYCLES = 10000;
    localparam int unsigned DEFAULT_REF_PERIOD  = 390;
    localparam int unsigned PENDING_W           = 3;

endpackage

// File: rtl/pkmc_load_downcounter.sv
// Loadable down-counter with a zero flag.
// Load takes priority over decrement.
module pkmc_load_downcounter #(
    parameter int unsigned CNT_W = 14
) (
    input  logic             clk,
    input  logic             load,
    input  logic [CNT_W-1:0] loadValue,
    input  logic             enable,
    output logic             zero
);

    logic [CNT_W-1:0] count;

    always_ff @(posedge clk) begin
        if (load) begin
            count <= loadValue;
        end else if (enable) begin
            count <= count - 1'b1;
        end
    end

    always_comb begin
        zero = (count == '0);
    end

endmodule

// File: rtl/pkmc_sdram_refresh_timer.sv
// SDRAM power-up delay and auto-refresh request generator with a bounded
// backlog of owed refreshes, feeding the pkmc controller FSM.
module pkmc_sdram_refresh_timer
    import pkmc_sdram_refresh_timer_pkg::*;
#(
    parameter int unsigned INIT_CYCLES = DEFAULT_INIT_CYCLES,
    parameter int unsigned REF_PERIOD  = DEFAULT_REF_PERIOD,
    parameter int unsigned MAX_PENDING = 4,
    parameter int unsigned CNT_W       = 14
) (
    input  logic                 clk_i,
    input  logic                 rst_n_i,
    input  logic                 enable_i,
    input  logic                 ref_ack_i,
    output logic                 init_done_o,
    output logic                 ref_req_o,
    output logic                 ref_urgent_o,
    output logic [PENDING_W-1:0] pending_o,
    output logic                 overflow_o
);

    localparam logic [CNT_W-1:0]     INIT_LOAD = CNT_W'(INIT_CYCLES - 1);
    localparam logic [CNT_W-1:0]     REF_LOAD  = CNT_W'(REF_PERIOD - 1);
    localparam logic [PENDING_W-1:0] PEND_MAX  = PENDING_W'(MAX_PENDING);
    localparam logic [PENDING_W-1:0] PEND_URG  = PENDING_W'(MAX_PENDING - 1);

    refState_e              state;
    logic                   cntZero;
    logic                   cntLoad;
    logic                   cntEn;
    logic [CNT_W-1:0]       cntLoadValue;
    logic                   tick;
    logic [PENDING_W-1:0]   pendNext;
    logic                   ovfSet;

    // Reset reuses the counter load path so the counter needs no reset of its own
    always_comb begin
        cntEn        = (state == PWRUP) || enable_i;
        tick         = (state == RUN) && enable_i && cntZero;
        cntLoad      = !rst_n_i || (cntEn && cntZero);
        cntLoadValue = rst_n_i ? REF_LOAD : INIT_LOAD;
    end

    always_comb begin
        pendNext = pending_o;
        ovfSet   = 1'b0;
        if (state == RUN) begin
            case ({tick, ref_ack_i})
                2'b10: begin
                    if (pending_o == PEND_MAX) begin
                        ovfSet = 1'b1;
                    end else begin
                        pendNext = pending_o + 1'b1;
                    end
                end
                2'b01: begin
                    if (pending_o != '0) begin
                        pendNext = pending_o - 1'b1;
                    end
                end
                default: pendNext = pending_o;
            endcase
        end
    end

    pkmc_load_downcounter #(
        .CNT_W (CNT_W)
    ) uCounter (
        .clk       (clk_i),
        .load      (cntLoad),
        .loadValue (cntLoadValue),
        .enable    (cntEn),
        .zero      (cntZero)
    );

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state        <= PWRUP;
            init_done_o  <= 1'b0;
            ref_req_o    <= 1'b0;
            ref_urgent_o <= 1'b0;
            pending_o    <= '0;
            overflow_o   <= 1'b0;
        end else begin
            if ((state == PWRUP) && cntZero) begin
                state       <= RUN;
                init_done_o <= 1'b1;
            end
            pending_o    <= pendNext;
            ref_req_o    <= (pendNext != '0);
            ref_urgent_o <= (pendNext >= PEND_URG);
            if (ovfSet) begin
                overflow_o <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_pkmc_sdram_refresh_timer.sv
// Bench for pkmc_sdram_refresh_timer: vector table, directed corner sequences
// and randomized traffic, all checked against a cycle-count reference model.
module tb_pkmc_sdram_refresh_timer;

    localparam int unsigned INIT = 20;
    localparam int unsigned REFP = 10;
    localparam int unsigned MAXP = 4;

    logic       clk = 1'b0;
    logic       rstN = 1'b0;
    logic       en = 1'b1;
    logic       ack = 1'b0;
    logic       initDone, refReq, refUrgent, overflow;
    logic [2:0] pending;

    int total = 0;
    int bad = 0;

    // reference model state: plain counts since reset / since init
    int mCyc = 0;
    int mEnCnt = 0;
    int mPend = 0;
    bit mInit = 1'b0;
    bit mOvf = 1'b0;

    typedef struct {
        logic        rstN;
        logic        en;
        logic        ack;
        int unsigned cycles;
        logic [6:0]  exp;
    } vec_t;

    vec_t tbl[$];

    pkmc_sdram_refresh_timer #(
        .INIT_CYCLES (INIT),
        .REF_PERIOD  (REFP),
        .MAX_PENDING (MAXP),
        .CNT_W       (14)
    ) dut (
        .clk_i        (clk),
        .rst_n_i      (rstN),
        .enable_i     (en),
        .ref_ack_i    (ack),
        .init_done_o  (initDone),
        .ref_req_o    (refReq),
        .ref_urgent_o (refUrgent),
        .pending_o    (pending),
        .overflow_o   (overflow)
    );

    always #5 clk = ~clk;

    function automatic logic [6:0] pk(input logic i, input logic r, input logic u,
                                      input int p, input logic o);
        return {i, r, u, 3'(p), o};
    endfunction

    function automatic logic [6:0] dutOut();
        return {initDone, refReq, refUrgent, pending, overflow};
    endfunction

    task automatic modelEdge(input logic r, input logic e, input logic a);
        bit t;
        t = 1'b0;
        if (!r) begin
            mCyc = 0; mEnCnt = 0; mPend = 0; mInit = 1'b0; mOvf = 1'b0;
        end else if (!mInit) begin
            mCyc++;
            if (mCyc == int'(INIT)) mInit = 1'b1;
        end else begin
            if (e) begin
                mEnCnt++;
                t = (mEnCnt % int'(REFP)) == 0;
            end
            if (t && !a) begin
                if (mPend == int'(MAXP)) mOvf = 1'b1;
                else mPend++;
            end else if (a && !t && mPend > 0) begin
                mPend--;
            end
        end
    endtask

    function automatic logic [6:0] modelOut();
        return pk(mInit, mPend > 0, mPend >= int'(MAXP) - 1, mPend, mOvf);
    endfunction

    task automatic check(input string name, input logic [6:0] exp);
        total++;
        if (dutOut() !== exp) begin
            bad++;
            $display("FAIL %s t=%0t got {init,req,urg,pend,ovf}=%b required=%b",
                     name, $time, dutOut(), exp);
        end
    endtask

    task automatic step(input logic r, input logic e, input logic a);
        rstN = r; en = e; ack = a;
        @(posedge clk);
        modelEdge(r, e, a);
        #1;
        check("model", modelOut());
    endtask

    task automatic doReset();
        step(1'b0, 1'b1, 1'b0);
    endtask

    task automatic runN(input int n, input logic e, input logic a);
        for (int i = 0; i < n; i++) step(1'b1, e, a);
    endtask

    initial begin
        // power-up, first tick, backlog saturation and overflow
        tbl.push_back('{1'b0, 1'b1, 1'b0,  1, pk(0, 0, 0, 0, 0)});
        tbl.push_back('{1'b1, 1'b1, 1'b0, 19, pk(0, 0, 0, 0, 0)});
        tbl.push_back('{1'b1, 1'b1, 1'b0,  1, pk(1, 0, 0, 0, 0)});
        tbl.push_back('{1'b1, 1'b1, 1'b0,  9, pk(1, 0, 0, 0, 0)});
        tbl.push_back('{1'b1, 1'b1, 1'b0,  1, pk(1, 1, 0, 1, 0)});
        tbl.push_back('{1'b1, 1'b1, 1'b0, 10, pk(1, 1, 0, 2, 0)});
        tbl.push_back('{1'b1, 1'b1, 1'b0, 10, pk(1, 1, 1, 3, 0)});
        tbl.push_back('{1'b1, 1'b1, 1'b0, 10, pk(1, 1, 1, 4, 0)});
        tbl.push_back('{1'b1, 1'b1, 1'b0, 10, pk(1, 1, 1, 4, 1)});
        tbl.push_back('{1'b1, 1'b1, 1'b0, 10, pk(1, 1, 1, 4, 1)});
        // tick+ack at saturation, lone acks, ack with empty backlog
        tbl.push_back('{1'b0, 1'b1, 1'b0,  1, pk(0, 0, 0, 0, 0)});
        tbl.push_back('{1'b1, 1'b1, 1'b0, 20, pk(1, 0, 0, 0, 0)});
        tbl.push_back('{1'b1, 1'b1, 1'b0, 40, pk(1, 1, 1, 4, 0)});
        tbl.push_back('{1'b1, 1'b1, 1'b0,  9, pk(1, 1, 1, 4, 0)});
        tbl.push_back('{1'b1, 1'b1, 1'b1,  1, pk(1, 1, 1, 4, 0)});
        tbl.push_back('{1'b1, 1'b1, 1'b1,  1, pk(1, 1, 1, 3, 0)});
        tbl.push_back('{1'b1, 1'b1, 1'b1,  3, pk(1, 0, 0, 0, 0)});
        tbl.push_back('{1'b1, 1'b1, 1'b1,  1, pk(1, 0, 0, 0, 0)});

        @(negedge clk);
        foreach (tbl[k]) begin
            for (int unsigned c = 0; c < tbl[k].cycles; c++)
                step(tbl[k].rstN, tbl[k].en, tbl[k].ack);
            check($sformatf("vec%0d", k), tbl[k].exp);
        end

        // ack two cycles after every tick: request high exactly two cycles
        doReset();
        runN(20, 1'b1, 1'b0);
        runN(10, 1'b1, 1'b0);
        check("ackLoopFirst", pk(1, 1, 0, 1, 0));
        for (int p = 0; p < 3; p++) begin
            step(1'b1, 1'b1, 1'b0);
            check("ackLoopHold", pk(1, 1, 0, 1, 0));
            step(1'b1, 1'b1, 1'b1);
            check("ackLoopClear", pk(1, 0, 0, 0, 0));
            runN(8, 1'b1, 1'b0);
            check("ackLoopTick", pk(1, 1, 0, 1, 0));
        end

        // freeze mid-interval; ack during freeze; tick resumes at remaining count
        doReset();
        runN(30, 1'b1, 1'b0);
        runN(5, 1'b1, 1'b0);
        runN(10, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b1);
        check("freezeAck", pk(1, 0, 0, 0, 0));
        runN(14, 1'b0, 1'b0);
        check("freezeNoTick", pk(1, 0, 0, 0, 0));
        runN(4, 1'b1, 1'b0);
        check("resumeBefore", pk(1, 0, 0, 0, 0));
        step(1'b1, 1'b1, 1'b0);
        check("resumeTick", pk(1, 1, 0, 1, 0));

        // reset mid-run with backlog 3; acks ignored during power-up
        doReset();
        runN(50, 1'b1, 1'b0);
        check("preReset", pk(1, 1, 1, 3, 0));
        doReset();
        check("midReset", pk(0, 0, 0, 0, 0));
        for (int i = 0; i < 19; i++) step(1'b1, 1'b1, 1'(i % 2));
        check("rePwrup", pk(0, 0, 0, 0, 0));
        step(1'b1, 1'b1, 1'b1);
        check("reInit", pk(1, 0, 0, 0, 0));

        // randomized traffic with occasional resets
        for (int i = 0; i < 3000; i++) begin
            step(1'($urandom_range(0, 299) != 0),
                 1'($urandom_range(0, 3) != 0),
                 1'($urandom_range(0, 7) == 0));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
